// File: rtl/ahb_rtl_pkg.sv
// Shared AHB-lite definitions for the SRAM slave and its memory array.
// Contents:
//   htrans_e      - AHB transfer type encoding
//   hsize_e       - AHB transfer size encoding (log2 of bytes)
//   HRESP_OKAY/ERROR - response constants
//   state_e       - data-phase state machine encoding
//   size_to_bytes - converts an hsize code into a byte count
package ahb_rtl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // hsize is log2(bytes), so the byte count is a simple shift.
  function automatic int unsigned size_to_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-enabled on-chip memory behind the AHB-lite SRAM slave.
// Synchronous write, combinational read; no reset on the contents.
// Ports:
//   hclk  - clock, writes take effect on the rising edge
//   we    - write enable
//   be    - per-byte-lane write enables
//   widx  - word index written
//   wdata - write data
//   ridx  - word index read
//   rdata - read data; a read of the word being written this cycle
//           sees the write data merged in under be
module ahb_sram_array
  import ahb_rtl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                       hclk,
  input  logic                       we,
  input  logic [DATA_WIDTH/8-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0]   widx,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   ridx,
  output logic [DATA_WIDTH-1:0]      rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Lane-masked write: untouched lanes keep their old contents.
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Forward the in-flight write so a read of the same word in the same
  // cycle already returns the new bytes.
  always_comb begin
    rdata = mem_q[ridx];
    if (we && (widx == ridx)) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          rdata[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave fronting a byte-enabled SRAM, with programmable wait
// states, byte-lane writes, range/alignment/size checking and a
// two-cycle ERROR response.
// Ports:
//   hclk, hreset   - clock and synchronous active-high reset
//   hsel, haddr, htrans, hwrite, hsize, hburst - address phase inputs
//   hwdata         - write data, valid in the data phase
//   hready         - bus-level HREADY
//   hreadyout      - slave ready (low during wait states and ERR1)
//   hresp          - 0 = OKAY, 1 = ERROR
//   hrdata         - read data, held between reads
module ahb_sram_slave
  import ahb_rtl_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter int unsigned            WAIT_STATES = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH * BYTES);

  state_e                  state_q, state_d;
  logic [2:0]              waitCnt_q, waitCnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [2:0]              size_q, size_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

  logic [ADDR_WIDTH-1:0]   addrOffset;
  logic [ADDR_WIDTH-1:0]   alignMask;
  int unsigned             sizeBytes;
  logic                    inRange;
  logic                    xferErr;
  logic                    canAccept;
  logic                    accept;

  logic                    memWe;
  logic [BYTES-1:0]        memBe;
  logic [DATA_WIDTH-1:0]   memRdata;
  int unsigned             laneLo;
  int unsigned             laneBytes;

  logic                    unusedBits;

  assign unusedBits = ^{hburst, htrans[0], addrOffset};

  // Address-phase checks. BASE_ADDR is aligned to the memory size, so the
  // low bits of haddr and of the offset agree for the alignment test.
  always_comb begin
    addrOffset = haddr - BASE_ADDR;
    sizeBytes  = size_to_bytes(hsize);
    alignMask  = ADDR_WIDTH'(sizeBytes - 32'd1);
    inRange    = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr} < END_ADDR);
    xferErr    = !inRange || ((haddr & alignMask) != '0) || (sizeBytes > BYTES);
  end

  // Only states that drive hreadyout high may take a new address phase;
  // during WAIT and ERR1 the bus is stalled and htrans is ignored.
  always_comb begin
    canAccept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    accept    = canAccept && hsel && hready && htrans[1];
  end

  // Next-state logic. IDLE, DATA and ERR2 all apply the same accept rules,
  // which lets back-to-back transfers pipeline without a bubble.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    write_d   = write_q;
    case (state_q)
      ST_WAIT: begin
        if (waitCnt_q == 3'd0) begin
          state_d = ST_DATA;
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          idx_d   = addrOffset[LANE_W +: IDX_W];
          lane_d  = haddr[LANE_W-1:0];
          size_d  = hsize;
          write_d = hwrite;
          if (xferErr) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d   = ST_WAIT;
            waitCnt_d = 3'(WAIT_STATES - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Lanes covered by the registered transfer. Erroring transfers never
  // reach DATA, so the span always fits inside one word here.
  always_comb begin
    memBe     = '0;
    laneLo    = 32'(lane_q);
    laneBytes = size_to_bytes(size_q);
    for (int unsigned i = 0; i < BYTES; i++) begin
      memBe[i] = (i >= laneLo) && (i < laneLo + laneBytes);
    end
  end

  // A write commits on the edge that ends DATA, unless reset hits that
  // same edge.
  assign memWe = (state_q == ST_DATA) && write_q && !hreset;

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .hclk  (hclk),
    .we    (memWe),
    .be    (memBe),
    .widx  (idx_q),
    .wdata (hwdata),
    .ridx  (idx_d),
    .rdata (memRdata)
  );

  // Read data is captured on the edge entering DATA, using the index that
  // DATA will own; a write retiring on that edge is forwarded by the array.
  always_comb begin
    hrdata_d = hrdata_q;
    if ((state_d == ST_DATA) && !write_d) begin
      hrdata_d = memRdata;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      write_q   <= write_d;
      hrdata_q  <= hrdata_d;
    end
  end

  // Response outputs depend only on the registered state.
  always_comb begin
    hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    hrdata    = hrdata_q;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed testbench for ahb_sram_slave. Two instances share one bus:
// dutFast has no wait states, dutSlow has three. slowSel picks which one
// is selected and which one drives the bus-level hready.
module tb_ahb_sram_slave;
  import ahb_rtl_pkg::*;

  logic        hclk;
  logic        hreset;
  logic        hselBus;
  logic        slowSel;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        ro0, resp0, ro1, resp1;
  logic [31:0] rd0, rd1;

  int assertCount = 0;
  int failCount   = 0;

  assign hsel0  = hselBus && !slowSel;
  assign hsel1  = hselBus && slowSel;
  assign hready = slowSel ? ro1 : ro0;

  ahb_sram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) dutFast (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
  );

  ahb_sram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)
  ) dutSlow (
    .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro1), .hresp(resp1), .hrdata(rd1)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] addr);
    hselBus = sel;
    htrans  = trans;
    hwrite  = wr;
    hsize   = size;
    haddr   = addr;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    idleBus();
    tick();
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL rst_fast_ready: got %b want 1", ro0); end
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL rst_fast_resp: got %b want 0", resp0); end
    assertCount++; if (rd0 !== 32'h0) begin failCount++; $display("[TB] FAIL rst_fast_rdata: got %h want 0", rd0); end
    assertCount++; if (ro1 !== 1'b1) begin failCount++; $display("[TB] FAIL rst_slow_ready: got %b want 1", ro1); end
    assertCount++; if (resp1 !== 1'b0) begin failCount++; $display("[TB] FAIL rst_slow_resp: got %b want 0", resp1); end
    assertCount++; if (rd1 !== 32'h0) begin failCount++; $display("[TB] FAIL rst_slow_rdata: got %h want 0", rd1); end
    hreset = 1'b0;
  endtask

  task automatic test_write_read();
    slowSel = 1'b0;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL wr_dphase_ready: got %b want 1", ro0); end
    hwdata = 32'hDEADBEEF;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL rd_dphase_ready: got %b want 1", ro0); end
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL rd_dphase_resp: got %b want 0", resp0); end
    assertCount++; if (rd0 !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rd_after_wr: got %h want deadbeef", rd0); end
    idleBus();
    hwdata = 32'h0;
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL idle_ready: got %b want 1", ro0); end
    assertCount++; if (rd0 !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rdata_hold: got %h want deadbeef", rd0); end
  endtask

  task automatic test_byte_write();
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    hwdata = 32'h0;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h11);
    tick();
    hwdata = 32'hAAAAAAAA;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (rd0 !== 32'h0000AA00) begin failCount++; $display("[TB] FAIL byte_hazard_rd: got %h want 0000aa00", rd0); end
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL byte_rd_resp: got %b want 0", resp0); end
    idleBus();
    hwdata = 32'h0;
    tick();
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (rd0 !== 32'h0000AA00) begin failCount++; $display("[TB] FAIL byte_plain_rd: got %h want 0000aa00", rd0); end
    idleBus();
    tick();
  endtask

  task automatic test_misaligned();
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h12);
    tick();
    assertCount++; if (resp0 !== 1'b1) begin failCount++; $display("[TB] FAIL mis_err1_resp: got %b want 1", resp0); end
    assertCount++; if (ro0 !== 1'b0) begin failCount++; $display("[TB] FAIL mis_err1_ready: got %b want 0", ro0); end
    idleBus();
    hwdata = 32'hFFFFFFFF;
    tick();
    assertCount++; if (resp0 !== 1'b1) begin failCount++; $display("[TB] FAIL mis_err2_resp: got %b want 1", resp0); end
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL mis_err2_ready: got %b want 1", ro0); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL mis_after_resp: got %b want 0", resp0); end
    assertCount++; if (rd0 !== 32'h0000AA00) begin failCount++; $display("[TB] FAIL mis_mem_unchanged: got %h want 0000aa00", rd0); end
    idleBus();
    tick();
  endtask

  task automatic test_idle_busy();
    hwdata = 32'h11111111;
    applyStimulus(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL busy_ready: got %b want 1", ro0); end
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL busy_resp: got %b want 0", resp0); end
    applyStimulus(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL idle_sel_ready: got %b want 1", ro0); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    tick();
    assertCount++; if (rd0 !== 32'h0000AA00) begin failCount++; $display("[TB] FAIL idle_no_write: got %h want 0000aa00", rd0); end
    idleBus();
    tick();
  endtask

  task automatic test_out_of_range();
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
    tick();
    hwdata = 32'h600DF00D;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h1000);
    tick();
    assertCount++; if (resp0 !== 1'b1) begin failCount++; $display("[TB] FAIL oor_err1_resp: got %b want 1", resp0); end
    assertCount++; if (ro0 !== 1'b0) begin failCount++; $display("[TB] FAIL oor_err1_ready: got %b want 0", ro0); end
    hwdata = 32'hFFFFFFFF;
    idleBus();
    tick();
    assertCount++; if (resp0 !== 1'b1) begin failCount++; $display("[TB] FAIL oor_err2_resp: got %b want 1", resp0); end
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL oor_err2_ready: got %b want 1", ro0); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL oor_next_ready: got %b want 1", ro0); end
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL oor_next_resp: got %b want 0", resp0); end
    hwdata = 32'h12345678;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
    tick();
    assertCount++; if (rd0 !== 32'h12345678) begin failCount++; $display("[TB] FAIL oor_next_data: got %h want 12345678", rd0); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
    tick();
    assertCount++; if (rd0 !== 32'h600DF00D) begin failCount++; $display("[TB] FAIL oor_no_alias: got %h want 600df00d", rd0); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 32'h10);
    tick();
    assertCount++; if (resp0 !== 1'b1) begin failCount++; $display("[TB] FAIL oversize_err1_resp: got %b want 1", resp0); end
    assertCount++; if (ro0 !== 1'b0) begin failCount++; $display("[TB] FAIL oversize_err1_ready: got %b want 0", ro0); end
    idleBus();
    tick();
    assertCount++; if (ro0 !== 1'b1) begin failCount++; $display("[TB] FAIL oversize_err2_ready: got %b want 1", ro0); end
    tick();
    assertCount++; if (resp0 !== 1'b0) begin failCount++; $display("[TB] FAIL oversize_back_okay: got %b want 0", resp0); end
  endtask

  task automatic test_wait_states();
    int lowCount;
    slowSel = 1'b1;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
    tick();
    assertCount++; if (ro1 !== 1'b0) begin failCount++; $display("[TB] FAIL ws_wr_wait1: got %b want 0", ro1); end
    hwdata = 32'hCAFEF00D;
    idleBus();
    tick();
    assertCount++; if (ro1 !== 1'b0) begin failCount++; $display("[TB] FAIL ws_wr_wait2: got %b want 0", ro1); end
    tick();
    assertCount++; if (ro1 !== 1'b0) begin failCount++; $display("[TB] FAIL ws_wr_wait3: got %b want 0", ro1); end
    tick();
    assertCount++; if (ro1 !== 1'b1) begin failCount++; $display("[TB] FAIL ws_wr_data: got %b want 1", ro1); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
    tick();
    idleBus();
    assertCount++; if (rd1 !== 32'h0) begin failCount++; $display("[TB] FAIL ws_rdata_hold: got %h want 0", rd1); end
    lowCount = 0;
    while (ro1 !== 1'b1 && lowCount < 10) begin
      lowCount++;
      tick();
    end
    assertCount++; if (lowCount !== 3) begin failCount++; $display("[TB] FAIL ws_low_cycles: got %0d want 3", lowCount); end
    assertCount++; if (resp1 !== 1'b0) begin failCount++; $display("[TB] FAIL ws_rd_resp: got %b want 0", resp1); end
    assertCount++; if (rd1 !== 32'hCAFEF00D) begin failCount++; $display("[TB] FAIL ws_rd_data: got %h want cafef00d", rd1); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int lowCount;
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
    tick();
    hwdata = 32'h55555555;
    idleBus();
    tick();
    assertCount++; if (ro1 !== 1'b0) begin failCount++; $display("[TB] FAIL rstw_in_wait: got %b want 0", ro1); end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    assertCount++; if (ro1 !== 1'b1) begin failCount++; $display("[TB] FAIL rstw_ready: got %b want 1", ro1); end
    assertCount++; if (resp1 !== 1'b0) begin failCount++; $display("[TB] FAIL rstw_resp: got %b want 0", resp1); end
    assertCount++; if (rd1 !== 32'h0) begin failCount++; $display("[TB] FAIL rstw_rdata: got %h want 0", rd1); end
    applyStimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
    tick();
    idleBus();
    lowCount = 0;
    while (ro1 !== 1'b1 && lowCount < 10) begin
      lowCount++;
      tick();
    end
    assertCount++; if (lowCount !== 3) begin failCount++; $display("[TB] FAIL rstw_rd_low: got %0d want 3", lowCount); end
    assertCount++; if (rd1 !== 32'hCAFEF00D) begin failCount++; $display("[TB] FAIL rstw_not_committed: got %h want cafef00d", rd1); end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    slowSel = 1'b0;
    hburst  = 3'b000;
    hwdata  = 32'h0;
    hreset  = 1'b1;
    idleBus();
    test_reset();
    test_write_read();
    test_byte_write();
    test_misaligned();
    test_idle_busy();
    test_out_of_range();
    test_wait_states();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
